// File: rtl/aes_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : aes_uart_pkg
//  Description : Shared constants for the UART <-> AES block bridge.
//                Holds the default block size, the RX/TX state encodings and
//                a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_uart_pkg;

   // Bytes per AES block
   localparam int unsigned BLOCK_BYTES_DEF = 16;

   // RX path states
   localparam logic [0:0] R_FILL = 1'b0;
   localparam logic [0:0] R_HOLD = 1'b1;

   // TX path states
   localparam logic [1:0] T_IDLE      = 2'd0;
   localparam logic [1:0] T_START     = 2'd1;
   localparam logic [1:0] T_WAIT_BUSY = 2'd2;
   localparam logic [1:0] T_WAIT_DONE = 2'd3;

   // Bits needed to index n items; never less than one bit
   function automatic int unsigned width_of(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_block_bridge_if.sv
`default_nettype none
// ============================================================================
//  Interface   : uart_block_bridge_if
//  Description : Valid/ready block bus carrying one AES block
//                (8*BLOCK_BYTES bits, byte 0 in the top byte lane).
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_block_bridge_if
   import aes_uart_pkg::*;
#(
   parameter int unsigned BLOCK_BYTES = BLOCK_BYTES_DEF
) ();

   logic [8*BLOCK_BYTES-1:0] data;
   logic                     valid;
   logic                     ready;

   // Producer of a block
   modport master (output data, output valid, input ready);
   // Consumer of a block
   modport slave  (input data, input valid, output ready);

endinterface
`default_nettype wire

// File: rtl/uart_block_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : uart_block_bridge
//  Description : Packs UART receive bytes into AES blocks (RX path) and
//                serialises AES result blocks into UART transmit bytes
//                (TX path). The two paths run independently.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_block_bridge
   import aes_uart_pkg::*;
#(
   parameter int unsigned BLOCK_BYTES  = BLOCK_BYTES_DEF,
   parameter int unsigned TIMEOUT_CLKS = 4340000
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   // UART receiver side
   input  wire logic [7:0]      i_rx_data,
   input  wire logic            i_rx_valid,
   // Block to the AES core
   uart_block_bridge_if.master  blk_in,
   // Result block from the AES core
   uart_block_bridge_if.slave   blk_out,
   // UART transmitter side
   output logic                 o_tx_start,
   output logic [7:0]           o_tx_data,
   input  wire logic            i_tx_busy,
   // Error pulses
   output logic                 o_overrun,
   output logic                 o_timeout_err
);

   localparam int unsigned c_cnt_w  = width_of(BLOCK_BYTES);
   localparam int unsigned c_idle_w = width_of(TIMEOUT_CLKS + 1);
   localparam int unsigned c_blk_w  = 8 * BLOCK_BYTES;

   localparam logic [c_cnt_w-1:0]  c_last_idx  = c_cnt_w'(BLOCK_BYTES - 1);
   // The idle counter fires on the TIMEOUT_CLKS-th idle clock
   localparam logic [c_idle_w-1:0] c_idle_last =
      c_idle_w'((TIMEOUT_CLKS == 0) ? 0 : TIMEOUT_CLKS - 1);
   localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
   localparam logic [c_idle_w-1:0] c_idle_one  = c_idle_w'(1);

   // ------------------------------------------------------------------------
   // RX path
   // ------------------------------------------------------------------------
   logic [0:0]          r_rx_state;
   logic [c_cnt_w-1:0]  r_rx_cnt;
   logic [c_blk_w-1:0]  r_blk_in_data;
   logic                r_blk_in_valid;
   logic [c_idle_w-1:0] r_idle_cnt;
   logic                r_overrun;
   logic                r_timeout_err;

   logic                w_rx_hs;
   logic                w_rx_accept;

   // A byte arriving on the handshake cycle starts the next block, so the
   // path accepts whenever it is filling or the held block is leaving.
   assign w_rx_hs     = r_blk_in_valid & blk_in.ready;
   assign w_rx_accept = i_rx_valid & ((r_rx_state == R_FILL) | w_rx_hs);

   // Byte collection, block presentation, overrun and idle timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_state     <= R_FILL;
         r_rx_cnt       <= '0;
         r_blk_in_data  <= '0;
         r_blk_in_valid <= 1'b0;
         r_idle_cnt     <= '0;
         r_overrun      <= 1'b0;
         r_timeout_err  <= 1'b0;
      end else begin
         r_overrun     <= 1'b0;
         r_timeout_err <= 1'b0;

         if (w_rx_hs) begin
            r_rx_state     <= R_FILL;
            r_blk_in_valid <= 1'b0;
         end

         if (w_rx_accept) begin
            // rx_cnt is already zero while holding, so a handshake-cycle
            // byte lands in byte lane 0
            for (int i = 0; i < BLOCK_BYTES; i++) begin
               if (r_rx_cnt == c_cnt_w'(i)) begin
                  r_blk_in_data[8*(BLOCK_BYTES-1-i) +: 8] <= i_rx_data;
               end
            end
            if (r_rx_cnt == c_last_idx) begin
               r_rx_state     <= R_HOLD;
               r_rx_cnt       <= '0;
               r_blk_in_valid <= 1'b1;
            end else begin
               r_rx_cnt <= r_rx_cnt + c_cnt_one;
            end
            r_idle_cnt <= '0;
         end else if (i_rx_valid) begin
            // Block held and not taken this cycle: the byte is lost
            r_overrun <= 1'b1;
         end else if ((r_rx_state == R_FILL) && (r_rx_cnt != '0) &&
                      (TIMEOUT_CLKS != 0)) begin
            if (r_idle_cnt == c_idle_last) begin
               r_rx_cnt      <= '0;
               r_idle_cnt    <= '0;
               r_timeout_err <= 1'b1;
            end else begin
               r_idle_cnt <= r_idle_cnt + c_idle_one;
            end
         end
      end
   end

   assign blk_in.data   = r_blk_in_data;
   assign blk_in.valid  = r_blk_in_valid;
   assign o_overrun     = r_overrun;
   assign o_timeout_err = r_timeout_err;

   // ------------------------------------------------------------------------
   // TX path
   // ------------------------------------------------------------------------
   logic [1:0]         r_tx_state;
   logic [c_cnt_w-1:0] r_tx_idx;
   logic [c_blk_w-1:0] r_tx_buf;
   logic               r_tx_start;
   logic [7:0]         r_tx_data;
   logic               r_out_ready;
   logic [7:0]         w_tx_byte;

   // Select byte tx_idx of the captured block, byte 0 in the top lane
   always_comb begin
      w_tx_byte = '0;
      for (int i = 0; i < BLOCK_BYTES; i++) begin
         if (r_tx_idx == c_cnt_w'(i)) begin
            w_tx_byte = r_tx_buf[8*(BLOCK_BYTES-1-i) +: 8];
         end
      end
   end

   // Block capture and byte-by-byte handoff to the transmitter.
   // Ready is registered so it stays low during reset and rises one clock
   // after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_state  <= T_IDLE;
         r_tx_idx    <= '0;
         r_tx_buf    <= '0;
         r_tx_start  <= 1'b0;
         r_tx_data   <= '0;
         r_out_ready <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;
         case (r_tx_state)
            T_IDLE: begin
               r_out_ready <= 1'b1;
               if (blk_out.valid && r_out_ready) begin
                  r_tx_buf    <= blk_out.data;
                  r_tx_idx    <= '0;
                  r_tx_state  <= T_START;
                  r_out_ready <= 1'b0;
               end
            end
            T_START: begin
               // Only launch a byte into an idle transmitter
               if (!i_tx_busy) begin
                  r_tx_start <= 1'b1;
                  r_tx_data  <= w_tx_byte;
                  r_tx_state <= T_WAIT_BUSY;
               end
            end
            T_WAIT_BUSY: begin
               if (i_tx_busy) begin
                  r_tx_state <= T_WAIT_DONE;
               end
            end
            T_WAIT_DONE: begin
               if (!i_tx_busy) begin
                  if (r_tx_idx == c_last_idx) begin
                     r_tx_state  <= T_IDLE;
                     r_out_ready <= 1'b1;
                  end else begin
                     r_tx_idx   <= r_tx_idx + c_cnt_one;
                     r_tx_state <= T_START;
                  end
               end
            end
            default: r_tx_state <= T_IDLE;
         endcase
      end
   end

   assign blk_out.ready = r_out_ready;
   assign o_tx_start    = r_tx_start;
   assign o_tx_data     = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_block_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_block_bridge
//  Description : Self-checking bench for uart_block_bridge with a UART
//                transmitter model and randomized block traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_block_bridge;
   import aes_uart_pkg::*;

   localparam int BB = 16;
   localparam int BW = 8 * BB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          tx_busy = 1'b0;
   logic          overrun;
   logic          timeout_err;

   uart_block_bridge_if #(.BLOCK_BYTES(BB)) blk_in_if ();
   uart_block_bridge_if #(.BLOCK_BYTES(BB)) blk_out_if ();

   uart_block_bridge #(.BLOCK_BYTES(BB), .TIMEOUT_CLKS(100)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_rx_data     (rx_data),
      .i_rx_valid    (rx_valid),
      .blk_in        (blk_in_if),
      .blk_out       (blk_out_if),
      .o_tx_start    (tx_start),
      .o_tx_data     (tx_data),
      .i_tx_busy     (tx_busy),
      .o_overrun     (overrun),
      .o_timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         n_ovr = 0;
   int         n_to = 0;
   int         n_rdy_viol = 0;
   int         tx_hold = 0;
   int         tx_base = 0;
   logic       tx_active = 1'b0;
   logic [7:0] tx_q[$];

   // Transmitter model: busy from the clock after a start strobe, for 10 clocks
   always @(posedge clk) begin
      if (tx_start) begin
         tx_busy <= 1'b1;
         tx_hold <= 10;
      end else if (tx_hold > 0) begin
         tx_hold <= tx_hold - 1;
         if (tx_hold == 1) tx_busy <= 1'b0;
      end
   end

   // Output monitor on the falling edge
   always @(negedge clk) begin
      if (tx_start) tx_q.push_back(tx_data);
      if (overrun) n_ovr <= n_ovr + 1;
      if (timeout_err) n_to <= n_to + 1;
      if (tx_active && ((tx_q.size() - tx_base) < BB) && blk_out_if.ready)
         n_rdy_viol <= n_rdy_viol + 1;
   end

   task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   function automatic logic [7:0] byte_of(input logic [BW-1:0] blk, input int i);
      return blk[8*(BB-1-i) +: 8];
   endfunction

   function automatic logic [BW-1:0] rand_blk();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic send_bytes(input logic [BW-1:0] blk, input int first, input int max_gap);
      for (int i = first; i < BB; i++) begin
         send_byte(byte_of(blk, i));
         if (i == BB - 2) chk("rx_not_yet_valid", blk_in_if.valid, 1'b0);
         if (i != BB - 1) idle($urandom_range(max_gap, 0));
      end
   endtask

   // Send a block, check presentation, then hand it over
   task automatic rx_block(input logic [BW-1:0] blk, input int max_gap,
                           input int rdy_dly, input logic early);
      blk_in_if.ready = early;
      send_bytes(blk, 0, max_gap);
      chk("rx_valid", blk_in_if.valid, 1'b1);
      chk("rx_data", blk_in_if.data, blk);
      if (!early) begin
         for (int k = 0; k < rdy_dly; k++) begin
            idle(1);
            chk("rx_hold_valid", blk_in_if.valid, 1'b1);
            chk("rx_hold_data", blk_in_if.data, blk);
         end
         blk_in_if.ready = 1'b1;
      end
      idle(1);
      blk_in_if.ready = 1'b0;
      chk("rx_released", blk_in_if.valid, 1'b0);
   endtask

   // Offer a result block and check the transmitted byte stream
   task automatic tx_block(input logic [BW-1:0] blk);
      int n;
      blk_out_if.data  = blk;
      blk_out_if.valid = 1'b1;
      n = 0;
      while (!blk_out_if.ready && n < 400) begin
         idle(1);
         n++;
      end
      chk("tx_ready_wait", blk_out_if.ready, 1'b1);
      tx_base   = tx_q.size();
      n_rdy_viol = 0;
      idle(1);
      blk_out_if.valid = 1'b0;
      blk_out_if.data  = rand_blk();
      tx_active = 1'b1;
      n = 0;
      while ((tx_q.size() - tx_base) < BB && n < BB * 20) begin
         idle(1);
         n++;
      end
      chk("tx_count", tx_q.size() - tx_base, BB);
      for (int i = 0; i < BB; i++) begin
         if (tx_base + i < tx_q.size()) chk("tx_byte", tx_q[tx_base + i], byte_of(blk, i));
      end
      n = 0;
      while (!blk_out_if.ready && n < 40) begin
         idle(1);
         n++;
      end
      tx_active = 1'b0;
      chk("tx_ready_after", blk_out_if.ready, 1'b1);
      chk("tx_ready_low_during", n_rdy_viol, 0);
      chk("tx_no_extra", tx_q.size() - tx_base, BB);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_in_valid"},  blk_in_if.valid, 1'b0);
      chk({tag, "_in_data"},   blk_in_if.data, '0);
      chk({tag, "_out_ready"}, blk_out_if.ready, 1'b0);
      chk({tag, "_tx_start"},  tx_start, 1'b0);
      chk({tag, "_tx_data"},   tx_data, 8'h00);
      chk({tag, "_overrun"},   overrun, 1'b0);
      chk({tag, "_timeout"},   timeout_err, 1'b0);
   endtask

   initial begin
      logic [BW-1:0] blk;
      logic [BW-1:0] blk2;
      int            ov0;
      int            to0;
      int            base;
      int            n;

      blk_in_if.ready  = 1'b0;
      blk_out_if.valid = 1'b0;
      blk_out_if.data  = '0;

      // Reset state
      idle(3);
      check_reset("reset");
      rst_n = 1'b1;
      idle(1);
      chk("ready_after_release", blk_out_if.ready, 1'b1);

      // Counting block with ready already high
      for (int i = 0; i < BB; i++) blk[8*(BB-1-i) +: 8] = 8'(i);
      rx_block(blk, 0, 0, 1'b1);

      // Random blocks, random gaps and ready delays
      for (int k = 0; k < 3; k++) rx_block(rand_blk(), 5, $urandom_range(4, 0), 1'b0);

      // Overrun while held, then byte on the handshake cycle
      ov0 = n_ovr;
      blk = rand_blk();
      blk_in_if.ready = 1'b0;
      send_bytes(blk, 0, 2);
      chk("ovr_pre_valid", blk_in_if.valid, 1'b1);
      send_byte(8'hAA);
      chk("ovr_pulse", overrun, 1'b1);
      chk("ovr_data_kept", blk_in_if.data, blk);
      idle(1);
      chk("ovr_single", overrun, 1'b0);
      chk("ovr_count", n_ovr - ov0, 1);
      blk_in_if.ready = 1'b1;
      send_byte(8'h55);
      blk_in_if.ready = 1'b0;
      chk("hs_no_ovr", overrun, 1'b0);
      chk("hs_valid_drop", blk_in_if.valid, 1'b0);
      blk2 = rand_blk();
      blk2[BW-1 -: 8] = 8'h55;
      send_bytes(blk2, 1, 2);
      chk("hs_next_valid", blk_in_if.valid, 1'b1);
      chk("hs_next_data", blk_in_if.data, blk2);
      blk_in_if.ready = 1'b1;
      idle(1);
      blk_in_if.ready = 1'b0;
      chk("hs_ovr_count", n_ovr - ov0, 1);

      // Partial block timeout
      to0 = n_to;
      for (int i = 0; i < 5; i++) send_byte(8'($urandom()));
      idle(90);
      chk("to_not_early", n_to - to0, 0);
      idle(15);
      chk("to_pulse_once", n_to - to0, 1);
      chk("to_no_valid", blk_in_if.valid, 1'b0);
      rx_block(rand_blk(), 3, 1, 1'b0);

      // Transmit path
      tx_block(128'h00112233445566778899AABBCCDDEEFF);
      tx_block(rand_blk());

      // Concurrent RX and TX
      ov0 = n_ovr;
      fork
         rx_block(rand_blk(), 4, 2, 1'b0);
         tx_block(rand_blk());
      join
      chk("conc_no_ovr", n_ovr - ov0, 0);

      // Reset mid-block on both paths
      blk_out_if.data  = rand_blk();
      blk_out_if.valid = 1'b1;
      n = 0;
      while (!blk_out_if.ready && n < 50) begin
         idle(1);
         n++;
      end
      base = tx_q.size();
      idle(1);
      blk_out_if.valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send_byte(8'($urandom()));
         idle(3);
      end
      n = 0;
      while ((tx_q.size() - base) < 3 && n < 200) begin
         idle(1);
         n++;
      end
      chk("pre_rst_tx3", (tx_q.size() - base) >= 3, 1'b1);
      rst_n = 1'b0;
      #1;
      check_reset("midrst");
      idle(2);
      chk("midrst_hold_ready", blk_out_if.ready, 1'b0);
      rst_n = 1'b1;
      idle(1);
      chk("midrst_ready_after", blk_out_if.ready, 1'b1);
      base = tx_q.size();
      idle(30);
      chk("no_resend", tx_q.size() - base, 0);
      chk("no_stale_block", blk_in_if.valid, 1'b0);
      rx_block(rand_blk(), 3, 1, 1'b0);
      tx_block(rand_blk());

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_block_bridge.md
UART_BLOCK_BRIDGE -- requirements
Module: uart_block_bridge

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 16, bytes per AES block.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 4340000, idle clocks before a partial RX block is discarded; 0 disables the timeout.
REQ-003 clk  in  1  clock; all logic on posedge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 rx_data  in  8  byte from the UART receiver.
REQ-006 rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-007 blk_in_data  out  8*BLOCK_BYTES  assembled block to the AES core.
REQ-008 blk_in_valid  out  1  assembled block available.
REQ-009 blk_in_ready  in  1  AES core accepts the block.
REQ-010 blk_out_data  in  8*BLOCK_BYTES  result block from the AES core.
REQ-011 blk_out_valid  in  1  result block available.
REQ-012 blk_out_ready  out  1  bridge accepts the result block.
REQ-013 tx_start  out  1  one-cycle start strobe to the UART transmitter.
REQ-014 tx_data  out  8  byte to the transmitter, stable while tx_start is high.
REQ-015 tx_busy  in  1  transmitter busy; rises the cycle after tx_start.
REQ-016 overrun  out  1  one-cycle pulse: byte dropped because the block was held.
REQ-017 timeout_err  out  1  one-cycle pulse: partial block discarded.

Function
REQ-018 RX path SHALL have two states: R_FILL (collecting bytes) and R_HOLD (block presented).
REQ-019 In R_FILL each rx_valid SHALL store the byte at index rx_cnt and increment rx_cnt; byte 0 lands in blk_in_data[8*BLOCK_BYTES-1 -: 8] (MSB-first).
REQ-020 When the byte at index BLOCK_BYTES-1 is stored, the path SHALL enter R_HOLD, clear rx_cnt, and assert blk_in_valid on the next cycle (1-cycle latency).
REQ-021 In R_HOLD, blk_in_data and blk_in_valid SHALL stay stable until the cycle in which blk_in_valid and blk_in_ready are both high; the path then returns to R_FILL.
REQ-022 An rx_valid in R_HOLD without a handshake in the same cycle SHALL drop the byte and pulse overrun.
REQ-023 An rx_valid in the same cycle as the RX handshake SHALL be stored as byte 0 of the next block, with no overrun.
REQ-024 In R_FILL with rx_cnt>0, the idle counter SHALL count clocks since the last rx_valid. On reaching TIMEOUT_CLKS, rx_cnt SHALL clear and timeout_err SHALL pulse. The counter SHALL not run when rx_cnt==0, in R_HOLD, or when TIMEOUT_CLKS==0.
REQ-025 TX path SHALL have four states: T_IDLE, T_START, T_WAIT_BUSY, T_WAIT_DONE.
REQ-026 blk_out_ready SHALL be 1 only in T_IDLE. A handshake SHALL capture blk_out_data, set tx_idx=0 and enter T_START.
REQ-027 T_START: entered only when tx_busy==0. The path SHALL drive tx_start=1 for exactly one cycle with tx_data = byte tx_idx (MSB-first), then enter T_WAIT_BUSY.
REQ-028 T_WAIT_BUSY SHALL wait for tx_busy==1, then enter T_WAIT_DONE.
REQ-029 T_WAIT_DONE SHALL wait for tx_busy==0. The path SHALL then go to T_IDLE if tx_idx==BLOCK_BYTES-1; otherwise it increments tx_idx and goes to T_START.
REQ-030 RX and TX paths SHALL operate independently and concurrently.
REQ-031 rx_cnt and tx_idx widths SHALL be $clog2(BLOCK_BYTES). The idle counter width SHALL hold TIMEOUT_CLKS.

Reset
REQ-032 On rst_n low, all state SHALL clear asynchronously: R_FILL, T_IDLE, rx_cnt=0, tx_idx=0, idle counter 0.
REQ-033 Output reset values: blk_in_valid=0, blk_in_data=0, blk_out_ready=0 (1 from the first cycle after release), tx_start=0, tx_data=0, overrun=0, timeout_err=0.
REQ-034 Reset during a partial block or mid-transmission SHALL discard it. No byte SHALL be resent after release.

Structure
REQ-035 BLOCK_BYTES default and the RX/TX state encodings SHALL live in shared package aes_uart_pkg.
REQ-036 The block SHALL be a single module with no sub-module; RX and TX halves are separate always blocks.

Verification
REQ-037 Send 16 bytes 0x00..0x0F with blk_in_ready=1 -> one cycle after the 16th rx_valid, blk_in_valid=1 with blk_in_data=0x000102...0F, then a handshake.
REQ-038 Hold blk_in_ready=0 after a full block and send byte 0xAA -> overrun pulses once and blk_in_data is unchanged. Raise blk_in_ready in the same cycle as rx_valid 0x55 -> no overrun, and the next block's byte 0 is 0x55.
REQ-039 TIMEOUT_CLKS=100: send 5 bytes, then idle 100 clocks -> timeout_err pulses once. Then 16 bytes -> block contains only those 16.
REQ-040 blk_out_data=0x00112233...FF, blk_out_valid=1, with a transmitter model (busy 1 cycle after start, held 10 clocks) -> 16 tx_start pulses carrying 0x00,0x11,...,0xFF in order. blk_out_ready=0 throughout, 1 after the last byte.
REQ-041 Run RX of one block concurrently with TX of another -> both complete correctly with no overrun.
REQ-042 Assert rst_n low after 8 RX bytes and 3 TX bytes -> all outputs at reset values. Afterwards a fresh 16-byte RX block and TX block complete normally.
